// File: rtl/escalonador_placar.sv
// escalonador_placar: time-multiplexes one digit recognizer over the scoreboard slots and commits the score atomically
module escalonador_placar #(
  parameter int NUM_DIGITOS    = 7,
  parameter int TIMEOUT_CICLOS = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  output logic [2:0]               sel_digito,
  output logic                     req_recon,
  input  logic                     ack_recon,
  input  logic [3:0]               digito_recon,
  output logic [4*NUM_DIGITOS-1:0] digitos,
  output logic [23:0]              placar,
  output logic [NUM_DIGITOS-1:0]   erro,
  output logic                     ocupado,
  output logic                     pronto
);
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
  typedef enum logic [1:0] {OCIOSO, REQ, ACUM, FIM} estado_t;
  estado_t est, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] cap, d;
  logic [23:0] acc, acc_n;
  logic [4*NUM_DIGITOS-1:0] dig_s;
  logic [NUM_DIGITOS-1:0] err_s, err_n, bit_sel;
  logic timeout, invalido;
  assign timeout   = cnt == CW'(TIMEOUT_CICLOS - 1);
  assign invalido  = cap > 4'd9;
  assign d         = invalido ? 4'd0 : cap;
  assign acc_n     = acc * 24'd10 + {20'd0, d};
  assign bit_sel   = {{(NUM_DIGITOS-1){1'b0}}, 1'b1} << (sel_digito - 3'd1);
  assign err_n     = invalido ? (err_s | bit_sel) : err_s;
  assign req_recon = est == REQ;
  assign ocupado   = est != OCIOSO;
  assign pronto    = est == FIM;
  // state register
  always_ff @(posedge clock)
    est <= reset ? OCIOSO : nxt;
  // next-state: an ack on the timeout cycle takes priority, ack outside REQ is never looked at
  always_comb begin
    nxt = est;
    case (est)
      OCIOSO:  nxt = iniciar ? REQ : OCIOSO;
      REQ:     nxt = (ack_recon || timeout) ? ACUM : REQ;
      ACUM:    nxt = sel_digito > 3'd1 ? REQ : FIM;
      default: nxt = OCIOSO;
    endcase
  end
  // scan datapath: scratch capture, Horner accumulation, commit on the last slot
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_digito <= '0;
      cnt        <= '0;
      cap        <= '0;
      acc        <= '0;
      dig_s      <= '0;
      err_s      <= '0;
      digitos    <= '0;
      placar     <= '0;
      erro       <= '0;
    end else begin
      case (est)
        OCIOSO: if (iniciar) begin
          sel_digito <= 3'(NUM_DIGITOS);
          cnt        <= '0;
          acc        <= '0;
          err_s      <= '0;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (ack_recon || timeout) begin
            cap <= ack_recon ? digito_recon : 4'hF;
            for (int i = 0; i < NUM_DIGITOS; i++)
              if (sel_digito == 3'(i + 1)) dig_s[4*i +: 4] <= ack_recon ? digito_recon : 4'hF;
          end
        end
        ACUM: begin
          acc   <= acc_n;
          err_s <= err_n;
          cnt   <= '0;
          if (sel_digito > 3'd1) sel_digito <= sel_digito - 3'd1;
          else begin
            sel_digito <= '0;
            digitos    <= dig_s;
            placar     <= acc_n;
            erro       <= err_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_escalonador_placar.sv
// tb_escalonador_placar: directed scans with a recognizer model and a scoreboard of committed results
module tb_escalonador_placar;
  logic clock = 0, reset = 1, iniciar = 0, ack_recon = 0;
  logic [3:0] digito_recon = 0;
  logic [2:0] sel_digito;
  logic req_recon, ocupado, pronto;
  logic [27:0] digitos;
  logic [23:0] placar;
  logic [6:0] erro;
  typedef struct {logic [27:0] dg; logic [23:0] pl; logic [6:0] er; int t;} exp_t;
  exp_t sb[$];
  logic [3:0] val [1:7];
  int dly [1:7];
  int total = 0, bad = 0, cyc = 0, wcnt = 0, exp_sel = 7;
  logic [2:0] prev_sel = 0;
  logic prev_req = 0, stray = 0;

  always #5 clock = ~clock;

  escalonador_placar dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .sel_digito(sel_digito),
    .req_recon(req_recon), .ack_recon(ack_recon), .digito_recon(digito_recon),
    .digitos(digitos), .placar(placar), .erro(erro), .ocupado(ocupado), .pronto(pronto)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (pronto) begin
      if (sb.size() == 0) chk("pronto_extra", 32'(pronto), 32'd0);
      else begin
        e = sb.pop_front();
        chk("placar", 32'(placar), 32'(e.pl));
        chk("digitos", 32'(digitos), 32'(e.dg));
        chk("erro", 32'(erro), 32'(e.er));
        chk("latencia", 32'(cyc), 32'(e.t));
      end
      exp_sel = 7;
    end
    if (req_recon && !prev_req) begin
      chk("sel_seq", 32'(sel_digito), 32'(exp_sel));
      exp_sel--;
    end else if (req_recon) chk("sel_estavel", 32'(sel_digito), 32'(prev_sel));
    prev_req = req_recon;
    prev_sel = sel_digito;
    if (req_recon && sel_digito != 0) begin
      ack_recon = dly[sel_digito] >= 0 && wcnt == dly[sel_digito];
      digito_recon = val[sel_digito];
      wcnt++;
    end else begin
      wcnt = 0;
      ack_recon = stray;
      digito_recon = 4'h9;
    end
  endtask

  task automatic launch();
    exp_t e;
    int lat;
    logic [3:0] d;
    lat = 1;
    e.pl = 0; e.dg = 0; e.er = 0;
    for (int s = 7; s >= 1; s--) begin
      d = dly[s] < 0 ? 4'hF : val[s];
      e.dg[4*s-4 +: 4] = d;
      if (d > 4'd9) e.er[s-1] = 1'b1;
      e.pl = e.pl * 24'd10 + ((d > 4'd9) ? 24'd0 : {20'd0, d});
      lat += (dly[s] < 0 ? 15 : dly[s] + 1) + 1;
    end
    e.t = cyc + lat;
    sb.push_back(e);
    iniciar = 1;
    tick();
    iniciar = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && (sb.size() != 0 || ocupado); i++) tick();
    chk("ocioso", 32'(ocupado), 32'd0);
    chk("sb_vazio", 32'(sb.size()), 32'd0);
  endtask

  task automatic set_all(input logic [3:0] v, input int dl);
    for (int s = 1; s <= 7; s++) begin val[s] = v; dly[s] = dl; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, 32'(sel_digito), 32'd0);
    chk({tag, "_req"}, 32'(req_recon), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    chk({tag, "_pronto"}, 32'(pronto), 32'd0);
    chk({tag, "_digitos"}, 32'(digitos), 32'd0);
    chk({tag, "_placar"}, 32'(placar), 32'd0);
    chk({tag, "_erro"}, 32'(erro), 32'd0);
  endtask

  initial begin
    set_all(4'd0, 0);
    repeat (3) tick();
    chk_zero("reset");
    reset = 0;
    tick();
    // immediate acks, slot 7 = 1 ... slot 1 = 7
    for (int s = 1; s <= 7; s++) begin val[s] = 4'(8 - s); dly[s] = 0; end
    launch();
    wait_done();
    // timeout on slot 4
    set_all(4'd9, 0);
    dly[4] = -1;
    launch();
    wait_done();
    // unrecognized digit on slot 7
    set_all(4'd0, 0);
    val[7] = 4'hC;
    launch();
    wait_done();
    // ignored restart and stray ack during ACUM
    for (int s = 1; s <= 7; s++) begin val[s] = 4'(8 - s); dly[s] = 0; end
    stray = 1;
    launch();
    repeat (4) tick();
    iniciar = 1;
    tick();
    iniciar = 0;
    wait_done();
    stray = 0;
    repeat (3) tick();
    chk("sem_fila", 32'(ocupado), 32'd0);
    // mid-scan reset after a 1234567 result
    launch();
    repeat (4) tick();
    reset = 1;
    tick();
    chk_zero("reset_meio");
    sb.delete();
    reset = 0;
    exp_sel = 7;
    repeat (20) tick();
    chk("reset_ocioso", 32'(ocupado), 32'd0);
    // delayed acks: three REQ cycles per slot
    val[7] = 4'd3; val[6] = 4'd1; val[5] = 4'd4; val[4] = 4'd1; val[3] = 4'd5; val[2] = 4'd9; val[1] = 4'd2;
    for (int s = 1; s <= 7; s++) dly[s] = 2;
    launch();
    wait_done();
    // ack on the timeout cycle wins, plus a real timeout in the same scan
    set_all(4'd8, 0);
    val[2] = 4'd5; dly[2] = 14;
    dly[5] = -1;
    launch();
    wait_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
